// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - Shared state encoding, default widths and slot packing helper
package adc_seq_pkg;

  localparam int DEF_NUM_FEAT = 6;
  localparam int DEF_ADC_W    = 8;
  localparam int DEF_FEAT_W   = 4;
  localparam int DEF_CLS_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_WAIT,
    ST_STORE,
    ST_PUBLISH,
    ST_CLASSIFY
  } seq_state_e;

  // Feature i occupies bits [width*i +: width] of the packed MLP input.
  function automatic int feat_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/adc_code_quant.sv
// rtl/adc_code_quant.sv - ADC_W to FEAT_W quantizer; FEAT_ROUND_EN selects round-to-nearest with saturation
module adc_code_quant #(
  parameter int ADC_W  = 8,
  parameter int FEAT_W = 4
) (
  input  logic [ADC_W-1:0]  code_i,
  output logic [FEAT_W-1:0] feat_o
);

`ifdef FEAT_ROUND_EN
  localparam logic [ADC_W:0] HALF_LSB = {{ADC_W{1'b0}}, 1'b1} << (ADC_W - FEAT_W - 1);

  logic [ADC_W:0] sum;

  // A carry into the extra bit means the rounded value no longer fits; clamp to full scale.
  assign sum    = {1'b0, code_i} + HALF_LSB;
  assign feat_o = sum[ADC_W] ? '1 : FEAT_W'(sum >> (ADC_W - FEAT_W));
`else
  assign feat_o = FEAT_W'(code_i >> (ADC_W - FEAT_W));
`endif

endmodule

// File: rtl/adc_feature_sequencer.sv
// rtl/adc_feature_sequencer.sv - Mux/ADC frame sequencer feeding the MLP; quantizer honours FEAT_ROUND_EN
module adc_feature_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_FEAT    = DEF_NUM_FEAT,
  parameter int ADC_W       = DEF_ADC_W,
  parameter int FEAT_W      = DEF_FEAT_W,
  parameter int CLS_W       = DEF_CLS_W,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [2:0]                 ch_sel,
  output logic                       adc_start,
  input  logic                       adc_done,
  input  logic [ADC_W-1:0]           adc_data,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  output logic                       frame_valid,
  input  logic [CLS_W-1:0]           cls_in,
  output logic [CLS_W-1:0]           cls_out,
  output logic                       cls_valid,
  output logic                       busy,
  output logic                       err
);

  localparam int VEC_W = NUM_FEAT * FEAT_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + SETTLE_CYC + 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic               err_q, err_d;
  logic [VEC_W-1:0]   shadow_q, shadow_d;
  logic [VEC_W-1:0]   feat_q, feat_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic [FEAT_W-1:0]  quant_feat;

  adc_code_quant #(
    .ADC_W  (ADC_W),
    .FEAT_W (FEAT_W)
  ) u_quant (
    .code_i (adc_data),
    .feat_o (quant_feat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      feat_q   <= '0;
      cls_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      feat_q   <= feat_d;
      cls_q    <= cls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    feat_d   = feat_q;
    cls_d    = cls_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A conversion landing in the final timeout cycle is still taken.
        if (adc_done) begin
          for (int i = 0; i < NUM_FEAT; i++) begin
            if (idx_q == 3'(i)) shadow_d[feat_lsb(i, FEAT_W) +: FEAT_W] = quant_feat;
          end
          state_d = ST_STORE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STORE: begin
        cnt_d = '0;
        if (idx_q == 3'(NUM_FEAT - 1)) begin
          // Load on entry to PUBLISH so feat_vec changes only while frame_valid is high.
          feat_d  = shadow_q;
          state_d = ST_PUBLISH;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_PUBLISH: begin
        cls_d   = cls_in;
        state_d = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ch_sel      = idx_q;
  assign adc_start   = (state_q == ST_CONVERT);
  assign frame_valid = (state_q == ST_PUBLISH);
  assign cls_valid   = (state_q == ST_CLASSIFY);
  assign busy        = (state_q != ST_IDLE);
  assign feat_vec    = feat_q;
  assign cls_out     = cls_q;
  assign err         = err_q;

endmodule

// File: tb/tb_adc_feature_sequencer.sv
// tb/tb_adc_feature_sequencer.sv - Scoreboard bench with ADC and MLP models for adc_feature_sequencer
module tb_adc_feature_sequencer;

  localparam int NUM_FEAT    = 6;
  localparam int ADC_W       = 8;
  localparam int FEAT_W      = 4;
  localparam int CLS_W       = 2;
  localparam int SETTLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int VW          = NUM_FEAT * FEAT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       ch_sel;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;
  logic [VW-1:0]    feat_vec;
  logic             frame_valid;
  logic [CLS_W-1:0] cls_in;
  logic [CLS_W-1:0] cls_out;
  logic             cls_valid;
  logic             busy;
  logic             err;

  logic             model_done = 1'b0;
  logic             stray_done = 1'b0;
  logic [ADC_W-1:0] model_data = '0;
  logic [ADC_W-1:0] stray_data = '0;

  int errors = 0;
  int checks = 0;
  int codes[NUM_FEAT];
  int adc_lat = 3;
  int hold_ch = -1;
  int cycle = 0;
  int n_adc = 0;
  int adc_base = 0;
  int n_frames = 0;
  int t_start = 0;
  int t_first_adc = 0;
  int t_last_adc = 0;
  int t_err_rise = 0;
  logic [VW-1:0]    exp_feat_q[$];
  logic [CLS_W-1:0] exp_cls_q[$];
  logic [VW-1:0]    last_good = '0;

  always #5 clk = ~clk;

  assign adc_done = model_done | stray_done;
  assign adc_data = model_done ? model_data : stray_data;

  // Stand-in classifier: sum of features modulo the class count.
  function automatic logic [CLS_W-1:0] mlp_model(input logic [VW-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < NUM_FEAT; i++) s += int'(v[FEAT_W*i +: FEAT_W]);
    return CLS_W'(s % (1 << CLS_W));
  endfunction

  assign cls_in = mlp_model(feat_vec);

  function automatic int quant(input int code);
    int r;
`ifdef FEAT_ROUND_EN
    r = (code + (1 << (ADC_W - FEAT_W - 1))) / (1 << (ADC_W - FEAT_W));
    if (r > (1 << FEAT_W) - 1) r = (1 << FEAT_W) - 1;
`else
    r = code / (1 << (ADC_W - FEAT_W));
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] expect_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FEAT; i++) v = v | (VW'(quant(codes[i])) << (FEAT_W * i));
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  adc_feature_sequencer #(
    .NUM_FEAT    (NUM_FEAT),
    .ADC_W       (ADC_W),
    .FEAT_W      (FEAT_W),
    .CLS_W       (CLS_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_sel      (ch_sel),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .feat_vec    (feat_vec),
    .frame_valid (frame_valid),
    .cls_in      (cls_in),
    .cls_out     (cls_out),
    .cls_valid   (cls_valid),
    .busy        (busy),
    .err         (err)
  );

  // ADC model: done strobe adc_lat cycles after the request, unless the channel is withheld.
  initial begin
    int ch;
    forever begin
      @(negedge clk);
      if (adc_start && int'(ch_sel) != hold_ch) begin
        ch = int'(ch_sel);
        repeat (adc_lat) @(negedge clk);
        model_data = ADC_W'(codes[ch]);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a frame or a class.
  initial begin
    logic prev_fv;
    logic prev_err;
    logic [VW-1:0] prev_feat;
    prev_fv = 1'b0;
    prev_err = 1'b0;
    prev_feat = '0;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (adc_start) begin
        if (n_adc == adc_base) t_first_adc = cycle;
        t_last_adc = cycle;
        check("ch_sel_order", ch_sel, n_adc - adc_base);
        n_adc++;
      end
      if (err && !prev_err) t_err_rise = cycle;
      if (frame_valid) begin
        n_frames++;
        if (exp_feat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got feat_vec 0x%0h expected no frame", feat_vec);
        end else begin
          check("feat_vec", feat_vec, exp_feat_q.pop_front());
        end
      end else if (!rst) begin
        check("feat_vec_stable", feat_vec, prev_feat);
      end
      if (cls_valid) begin
        if (exp_cls_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cls: got cls_out %0d expected no class", cls_out);
        end else begin
          check("cls_out", cls_out, exp_cls_q.pop_front());
        end
      end
      if (cls_valid || prev_fv) check("cls_valid_follows_frame", cls_valid, prev_fv);
      prev_fv = frame_valid;
      prev_err = err;
      prev_feat = feat_vec;
    end
  end

  task automatic run_frame(input string tag, input int lat, input int hold, input bit stray, input bit poke);
    int adc0;
    int fr0;
    int cyc;
    logic [VW-1:0] ev;
    adc_lat = lat;
    hold_ch = hold;
    adc0 = n_adc;
    adc_base = n_adc;
    fr0 = n_frames;
    ev = expect_vec();
    if (hold < 0) begin
      exp_feat_q.push_back(ev);
      exp_cls_q.push_back(mlp_model(ev));
    end
    @(negedge clk);
    start = 1'b1;
    t_start = cycle;
    @(negedge clk);
    start = 1'b0;
    if (stray) begin
      stray_data = ADC_W'($urandom);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 12);
    end
    start = 1'b0;
    check({tag, "_frame_bounded"}, (cyc < 3000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    check({tag, "_start_to_adc"}, t_first_adc - t_start, 1 + SETTLE_CYC);
    check({tag, "_busy_low"}, busy, 0);
    if (hold < 0) begin
      check({tag, "_err"}, err, 0);
      check({tag, "_frames"}, n_frames - fr0, 1);
      check({tag, "_adc_starts"}, n_adc - adc0, NUM_FEAT);
      last_good = ev;
    end else begin
      check({tag, "_err"}, err, 1);
      check({tag, "_frames"}, n_frames - fr0, 0);
      check({tag, "_adc_starts"}, n_adc - adc0, hold + 1);
      check({tag, "_feat_kept"}, feat_vec, last_good);
      check({tag, "_err_delay"}, t_err_rise - t_last_adc, TIMEOUT_CYC + 1);
    end
  endtask

  task automatic randomize_codes();
    for (int i = 0; i < NUM_FEAT; i++) codes[i] = int'($urandom_range(0, (1 << ADC_W) - 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch_sel"}, ch_sel, 0);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_feat_vec"}, feat_vec, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_cls_out"}, cls_out, 0);
    check({tag, "_cls_valid"}, cls_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    codes = '{16, 32, 48, 64, 80, 240};
    run_frame("nominal", 3, -1, 1'b0, 1'b0);
    check("nominal_vec", feat_vec, 24'hF54321);
    check("nominal_cls", cls_out, mlp_model(24'hF54321));

    randomize_codes();
    codes[0] = 249;
    codes[1] = 24;
    run_frame("round", 2, -1, 1'b0, 1'b0);
    check("round_f9", feat_vec[3:0], 15);
`ifdef FEAT_ROUND_EN
    check("round_18", feat_vec[7:4], 2);
`else
    check("round_18", feat_vec[7:4], 1);
`endif

    randomize_codes();
    run_frame("stray_busy", 3, -1, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      randomize_codes();
      run_frame("rand", int'($urandom_range(1, 6)), -1, 1'b0, 1'b0);
    end

    randomize_codes();
    run_frame("race", TIMEOUT_CYC, -1, 1'b0, 1'b0);

    randomize_codes();
    run_frame("timeout", 3, 3, 1'b0, 1'b0);

    randomize_codes();
    adc_lat = 3;
    hold_ch = -1;
    adc_base = n_adc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((n_adc - adc_base) < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_ch2", (cyc < 500) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    last_good = '0;
    repeat (10) @(negedge clk);

    randomize_codes();
    run_frame("after_reset", 3, -1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_feat_drained", exp_feat_q.size(), 0);
    check("sb_cls_drained", exp_cls_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
